// File: rtl/csr_mtrap_file.sv
// csr_mtrap_file: machine-mode CSR file with trap entry/mret sequencing and 64-bit mcycle/minstret counters.
module csr_mtrap_file #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] MVENDORID    = 32'h79737978,
  parameter logic [31:0] MARCHID      = 32'h015FDE21,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_csr_wdata1,
  input  logic [11:0]     i_csr_waddr1,
  input  logic            i_csr_wena1,
  input  logic [XLEN-1:0] i_csr_wdata2,
  input  logic [11:0]     i_csr_waddr2,
  input  logic            i_csr_wena2,
  input  logic [11:0]     i_csr_raddr,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_mret,
  input  logic            i_instret,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);
  localparam int PW = XLEN + 13;
  logic [PW-1:0] p1, p2;
  assign p1 = {i_csr_wena1, i_csr_waddr1, i_csr_wdata1};
  assign p2 = {i_csr_wena2, i_csr_waddr2, i_csr_wdata2};
  // returns {hit, data}; port 2 outranks port 1 on the same address
  function automatic logic [XLEN:0] wsel(input logic [11:0] a, input logic [PW-1:0] x1, input logic [PW-1:0] x2);
    return (x2[PW-1] && x2[PW-2 -: 12] == a) ? {1'b1, x2[XLEN-1:0]}
                                              : {x1[PW-1] && x1[PW-2 -: 12] == a, x1[XLEN-1:0]};
  endfunction
  function automatic logic [63:0] cnt_nxt(input logic [63:0] cur, input logic inc, input logic wl,
                                          input logic [63:0] dl, input logic wh, input logic [63:0] dh);
    if (!HAS_COUNTERS) return 64'd0;
    if (wl || wh)
      return {wh ? dh[31:0] : ((XLEN == 64 && wl) ? dl[63:32] : cur[63:32]), wl ? dl[31:0] : cur[31:0]};
    return cur + 64'(inc);
  endfunction
  logic            mie, mpie;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause;
  logic [63:0]     mcycle, minstret;
  logic            w_st, w_tv, w_sc, w_ep, w_ca, w_cl, w_ch_raw, w_il, w_ih_raw, w_ch, w_ih;
  logic [XLEN-1:0] d_st, d_tv, d_sc, d_ep, d_ca, d_cl, d_ch, d_il, d_ih;
  assign {w_st, d_st}     = wsel(12'h300, p1, p2);
  assign {w_tv, d_tv}     = wsel(12'h305, p1, p2);
  assign {w_sc, d_sc}     = wsel(12'h340, p1, p2);
  assign {w_ep, d_ep}     = wsel(12'h341, p1, p2);
  assign {w_ca, d_ca}     = wsel(12'h342, p1, p2);
  assign {w_cl, d_cl}     = wsel(12'hB00, p1, p2);
  assign {w_ch_raw, d_ch} = wsel(12'hB80, p1, p2);
  assign {w_il, d_il}     = wsel(12'hB02, p1, p2);
  assign {w_ih_raw, d_ih} = wsel(12'hB82, p1, p2);
  assign w_ch = XLEN == 32 && w_ch_raw;
  assign w_ih = XLEN == 32 && w_ih_raw;
  logic mret_eff;
  assign mret_eff = i_mret && !i_trap_valid;
  logic [63:0] mcycle_nxt, minstret_nxt;
  assign mcycle_nxt   = cnt_nxt(mcycle, 1'b1, w_cl, 64'(d_cl), w_ch, 64'(d_ch));
  assign minstret_nxt = cnt_nxt(minstret, i_instret, w_il, 64'(d_il), w_ih, 64'(d_ih));
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mie              <= 1'b0;
      mpie             <= 1'b0;
      mtvec            <= '0;
      mscratch         <= '0;
      mepc             <= '0;
      mcause           <= '0;
      mcycle           <= '0;
      minstret         <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      mie              <= i_trap_valid ? 1'b0 : mret_eff ? mpie : w_st ? d_st[3] : mie;
      mpie             <= i_trap_valid ? mie : mret_eff ? 1'b1 : w_st ? d_st[7] : mpie;
      mtvec            <= w_tv ? {d_tv[XLEN-1:2], 2'b00} : mtvec;
      mscratch         <= w_sc ? d_sc : mscratch;
      mepc             <= i_trap_valid ? {i_trap_pc[XLEN-1:1], 1'b0} : w_ep ? {d_ep[XLEN-1:1], 1'b0} : mepc;
      mcause           <= i_trap_valid ? i_trap_cause : w_ca ? d_ca : mcause;
      mcycle           <= mcycle_nxt;
      minstret         <= minstret_nxt;
      o_redirect_valid <= i_trap_valid || mret_eff;
      o_redirect_pc    <= i_trap_valid ? mtvec : mret_eff ? mepc : o_redirect_pc;
    end
  end
  always_comb begin
    o_csr_rdata   = '0;
    o_csr_illegal = 1'b0;
    case (i_csr_raddr)
      12'h300: o_csr_rdata = XLEN'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});
      12'h305: o_csr_rdata = mtvec;
      12'h340: o_csr_rdata = mscratch;
      12'h341: o_csr_rdata = mepc;
      12'h342: o_csr_rdata = mcause;
      12'hB00: o_csr_rdata = mcycle[XLEN-1:0];
      12'hB02: o_csr_rdata = minstret[XLEN-1:0];
      12'hB80: if (XLEN == 32) o_csr_rdata = XLEN'(mcycle[63:32]); else o_csr_illegal = 1'b1;
      12'hB82: if (XLEN == 32) o_csr_rdata = XLEN'(minstret[63:32]); else o_csr_illegal = 1'b1;
      12'hF11: o_csr_rdata = XLEN'(MVENDORID);
      12'hF12: o_csr_rdata = XLEN'(MARCHID);
      default: o_csr_illegal = 1'b1;
    endcase
  end
  logic unused;
  assign unused = ^{d_st, d_tv[1:0], d_ep[0], d_ch, d_ih, mcycle, minstret};
endmodule

// File: tb/tb_csr_mtrap_file.sv
// tb_csr_mtrap_file: directed vector table plus hand sequences for trap/mret, counters and async reset.
module tb_csr_mtrap_file;
  logic        clk = 0, rst = 0;
  logic [31:0] wd1 = 0, wd2 = 0, cause = 0, tpc = 0;
  logic [11:0] wa1 = 0, wa2 = 0, ra = 0;
  logic        we1 = 0, we2 = 0, trap = 0, mret = 0, instret = 0;
  logic [31:0] rd, rpc;
  logic        ill, rv;
  int          n_vec = 0, n_bad = 0;
  csr_mtrap_file dut (
    .i_clk(clk), .i_rst(rst),
    .i_csr_wdata1(wd1), .i_csr_waddr1(wa1), .i_csr_wena1(we1),
    .i_csr_wdata2(wd2), .i_csr_waddr2(wa2), .i_csr_wena2(we2),
    .i_csr_raddr(ra), .o_csr_rdata(rd), .o_csr_illegal(ill),
    .i_trap_valid(trap), .i_trap_cause(cause), .i_trap_pc(tpc),
    .i_mret(mret), .i_instret(instret),
    .o_redirect_valid(rv), .o_redirect_pc(rpc)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we1;
    logic [11:0] wa1;
    logic [31:0] wd1;
    logic        we2;
    logic [11:0] wa2;
    logic [31:0] wd2;
    logic [11:0] ra;
    logic [31:0] rd;
    logic        ill;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rdchk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    ra = a;
    #1;
    chk(nm, rd, exp);
  endtask
  initial begin
    v[0]  = '{1, 12'h305, 32'h80000103, 0, 12'h000, 32'h0,  12'h305, 32'h80000100, 0};
    v[1]  = '{0, 12'h000, 32'h0,        0, 12'h000, 32'h0,  12'h300, 32'h00001800, 0};
    v[2]  = '{1, 12'h340, 32'h11,       1, 12'h340, 32'h22, 12'h340, 32'h00000022, 0};
    v[3]  = '{1, 12'h341, 32'h1235,     1, 12'h342, 32'h7,  12'h341, 32'h00001234, 0};
    v[4]  = '{0, 12'h000, 32'h0,        0, 12'h000, 32'h0,  12'h342, 32'h00000007, 0};
    v[5]  = '{1, 12'hF11, 32'h0,        0, 12'h000, 32'h0,  12'hF11, 32'h79737978, 0};
    v[6]  = '{0, 12'h000, 32'h0,        1, 12'hF12, 32'h5,  12'hF12, 32'h015FDE21, 0};
    v[7]  = '{1, 12'h7C0, 32'h1234,     0, 12'h000, 32'h0,  12'h7C0, 32'h00000000, 1};
    v[8]  = '{1, 12'h300, 32'hFFFFFFFF, 0, 12'h000, 32'h0,  12'h300, 32'h00001888, 0};
    v[9]  = '{1, 12'h300, 32'h0,        0, 12'h000, 32'h0,  12'h300, 32'h00001800, 0};
    v[10] = '{0, 12'h000, 32'h0,        0, 12'h000, 32'h0,  12'hB02, 32'h00000000, 0};
    v[11] = '{0, 12'h000, 32'h0,        0, 12'h000, 32'h0,  12'hB80, 32'h00000000, 0};
    v[12] = '{1, 12'h341, 32'h80000043, 0, 12'h000, 32'h0,  12'h341, 32'h80000042, 0};
    #1 rst = 1;
    #1;
    chk("rst_rv", 32'(rv), 32'h0);
    chk("rst_rpc", rpc, 32'h0);
    rdchk("rst_mstatus", 12'h300, 32'h1800);
    rdchk("rst_mepc", 12'h341, 32'h0);
    tick;
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      we1 = v[i].we1; wa1 = v[i].wa1; wd1 = v[i].wd1;
      we2 = v[i].we2; wa2 = v[i].wa2; wd2 = v[i].wd2;
      tick;
      we1 = 0; we2 = 0;
      rdchk($sformatf("vec%0d_rdata", i), v[i].ra, v[i].rd);
      chk($sformatf("vec%0d_illegal", i), 32'(ill), 32'(v[i].ill));
    end
    // trap with same-cycle mtvec write (must not affect redirect) and lower-priority mepc write
    we1 = 1; wa1 = 12'h300; wd1 = 32'h8;
    tick;
    trap = 1; cause = 32'hB; tpc = 32'h80000043;
    we1 = 1; wa1 = 12'h305; wd1 = 32'h90000000;
    we2 = 1; wa2 = 12'h341; wd2 = 32'h5554;
    tick;
    trap = 0; we1 = 0; we2 = 0;
    chk("trap_rv", 32'(rv), 32'h1);
    chk("trap_rpc", rpc, 32'h80000100);
    rdchk("trap_mepc", 12'h341, 32'h80000042);
    rdchk("trap_mcause", 12'h342, 32'hB);
    rdchk("trap_mstatus", 12'h300, 32'h1880);
    rdchk("trap_mtvec", 12'h305, 32'h90000000);
    tick;
    chk("trap_rv_drop", 32'(rv), 32'h0);
    mret = 1;
    tick;
    mret = 0;
    chk("mret_rv", 32'(rv), 32'h1);
    chk("mret_rpc", rpc, 32'h80000042);
    rdchk("mret_mstatus", 12'h300, 32'h1888);
    tick;
    chk("mret_rv_drop", 32'(rv), 32'h0);
    trap = 1; mret = 1; cause = 32'h3; tpc = 32'h80000200;
    tick;
    trap = 0; mret = 0;
    chk("both_rv", 32'(rv), 32'h1);
    chk("both_rpc", rpc, 32'h90000000);
    rdchk("both_mstatus", 12'h300, 32'h1880);
    rdchk("both_mepc", 12'h341, 32'h80000200);
    rdchk("both_mcause", 12'h342, 32'h3);
    // mcycle carry out of the low half
    we1 = 1; wa1 = 12'hB00; wd1 = 32'hFFFFFFFF;
    we2 = 1; wa2 = 12'hB80; wd2 = 32'h0;
    tick;
    we1 = 0; we2 = 0;
    rdchk("mcyc_wr_lo", 12'hB00, 32'hFFFFFFFF);
    rdchk("mcyc_wr_hi", 12'hB80, 32'h0);
    tick;
    rdchk("mcyc_carry_hi", 12'hB80, 32'h1);
    rdchk("mcyc_carry_lo", 12'hB00, 32'h0);
    repeat (3) begin
      instret = 1;
      tick;
      instret = 0;
      tick;
    end
    rdchk("minstret_3", 12'hB02, 32'h3);
    instret = 1; we1 = 1; wa1 = 12'hB02; wd1 = 32'h10;
    tick;
    instret = 0; we1 = 0;
    rdchk("minstret_wr_wins", 12'hB02, 32'h10);
    we1 = 1; wa1 = 12'hB02; wd1 = 32'hFFFFFFFF;
    we2 = 1; wa2 = 12'hB82; wd2 = 32'hFFFFFFFF;
    tick;
    we1 = 0; we2 = 0; instret = 1;
    tick;
    instret = 0;
    rdchk("minstret_wrap_lo", 12'hB02, 32'h0);
    rdchk("minstret_wrap_hi", 12'hB82, 32'h0);
    // async reset while a redirect is being presented
    trap = 1; cause = 32'h2; tpc = 32'h80000010;
    tick;
    trap = 0;
    chk("pre_rst_rv", 32'(rv), 32'h1);
    #2 rst = 1;
    #1;
    chk("async_rst_rv", 32'(rv), 32'h0);
    chk("async_rst_rpc", rpc, 32'h0);
    rdchk("async_rst_mepc", 12'h341, 32'h0);
    rdchk("async_rst_mtvec", 12'h305, 32'h0);
    tick;
    rst = 0;
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/csr_mtrap_file.md
Name: csr_mtrap_file

Overview:
Parametrised machine-mode CSR file for the write-back stage. It extends the four-register CSR store with the following:
- XLEN generalisation.
- mscratch.
- A free-running 64-bit mcycle counter and a minstret counter.
- Hardware trap entry and mret sequencing that update mstatus/mepc/mcause atomically.

The block is written from WBU commit and read combinationally by the IDU/EXU. It supplies the redirect target to the IFU.

Parameters:
XLEN, 32, data width of all CSRs and data ports (32 or 64).
MVENDORID, 32'h79737978, read-only value at 12'hF11.
MARCHID, 32'h015FDE21, read-only value at 12'hF12.
HAS_COUNTERS, 1, 1 = mcycle/minstret implemented; 0 = those addresses read 0, writes ignored.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_csr_wdata1  in  XLEN  write port 1 data
i_csr_waddr1  in  12  write port 1 address
i_csr_wena1  in  1  write port 1 enable
i_csr_wdata2  in  XLEN  write port 2 data
i_csr_waddr2  in  12  write port 2 address
i_csr_wena2  in  1  write port 2 enable
i_csr_raddr  in  12  read address
o_csr_rdata  out  XLEN  read data, combinational
o_csr_illegal  out  1  raddr is unmapped, combinational
i_trap_valid  in  1  take trap this cycle
i_trap_cause  in  XLEN  cause value for the trap
i_trap_pc  in  XLEN  PC of the faulting instruction
i_mret  in  1  execute mret this cycle
i_instret  in  1  one instruction retired this cycle
o_redirect_valid  out  1  registered; redirect the IFU
o_redirect_pc  out  XLEN  registered redirect target

Behaviour:
Address map:
- 300 mstatus.
- 305 mtvec.
- 340 mscratch.
- 341 mepc.
- 342 mcause.
- B00 mcycle low.
- B80 mcycle high (XLEN=32 only).
- B02 minstret low.
- B82 minstret high (XLEN=32 only).
- F11 MVENDORID.
- F12 MARCHID.
- Any other raddr: rdata=0, o_csr_illegal=1.
- Writes to F11/F12 or to unmapped addresses are ignored.

mstatus:
- Only MIE (bit 3) and MPIE (bit 7) are writable.
- MPP [12:11] reads constant 2'b11.
- All other bits read 0.

mtvec and mepc:
- mtvec bits [1:0] are forced to 0 on write (direct mode only).
- mepc bit 0 is forced to 0 on write.

Reset (async assert, sync-safe release):
- All CSRs and counters are 0.
- o_redirect_valid=0, o_redirect_pc=0.
- Reset asserted mid-operation clears everything, including a pending redirect, on the same edge.

Per-register write priority at a posedge, highest first:
1. Trap.
2. mret.
3. Port 2.
4. Port 1.
5. Counter increment.
Lower-priority updates to a register that a higher-priority source modifies are dropped. Independent registers update in the same cycle.

Trap (i_trap_valid=1):
- mepc <= i_trap_pc & ~1.
- mcause <= i_trap_cause.
- MPIE <= MIE.
- MIE <= 0.
- o_redirect_pc <= mtvec; o_redirect_valid <= 1 for exactly one cycle.

mret (i_mret=1, no trap):
- MIE <= MPIE.
- MPIE <= 1.
- o_redirect_pc <= mepc; o_redirect_valid <= 1 for one cycle.

Trap and mret in the same cycle: the trap wins and the mret is discarded.

Redirect timing: the redirect uses the pre-edge value of mtvec/mepc. A same-cycle CSR write to mtvec is not seen until the next trap.

mcycle:
- 64-bit; +1 every cycle.
- A software write replaces the addressed half only. That half takes the written value with no increment that cycle; the other half holds.
- Carry wraps 0xFFFF_FFFF_FFFF_FFFF to 0.

minstret:
- 64-bit; +1 when i_instret=1.
- Same write and wrap rules as mcycle.

Read behaviour:
- Reads are combinational from current state.
- There is no write-to-read bypass: a write becomes visible the cycle after the edge.
- XLEN=64: B00/B02 return the full 64-bit value; B80/B82 are unmapped.

Test Plan:
- Reset, then write 305<=0x8000_0103 via port 1 -> read 305 = 0x8000_0100; read 300 = 0x0000_1800.
- Both ports write 340 the same cycle (p1 0x11, p2 0x22) -> mscratch = 0x22. Ports write 341 and 342 the same cycle -> both updated.
- MIE=1, mtvec=0x8000_0100, trap cause=0xB, pc=0x8000_0043 -> next cycle: mepc=0x8000_0042, mcause=0xB, mstatus=0x1880, o_redirect_valid=1 for one cycle with pc 0x8000_0100.
- mret after the above trap -> mstatus=0x1888, redirect pc 0x8000_0042. Trap+mret in the same cycle -> trap behaviour only.
- Write B00<=0xFFFF_FFFF, B80<=0 -> the next read of B80 = 1, B00 = 0. Pulse i_instret 3 times -> B02 = 3. Write F11 -> still 0x79737978.
- Read 0x7C0 -> rdata = 0, o_csr_illegal = 1. Assert i_rst asynchronously mid-redirect -> outputs go to 0 immediately, without waiting for a clock edge.
